// File: rtl/apb_slave_mem.sv
// ============================================================================
// apb_slave_mem : APB completer backed by a word-addressed register file.
// Optional macro APB_SLV_WAIT_EN adds WAIT_CYCLES wait states per transfer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_slave_mem #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hDEADCA00,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic              pready_o,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pslverr_o
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES > 15) begin : g_param_check
    $error("apb_slave_mem: DEPTH must be a power of two >= 2 and WAIT_CYCLES <= 15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic                inr_q;

  logic [ADDR_W-1:0]   offset;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                setup;
  logic                commit;

  // Subtraction wraps below BASE_ADDR, so one unsigned compare covers both ends.
  assign offset   = paddr_i - BASE_ADDR;
  assign in_range = (offset < WIN_BYTES);
  assign idx      = offset[IDX_W+1:2];

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    setup   = 1'b0;
    commit  = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          setup = 1'b1;
`ifdef APB_SLV_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      S_WAIT: begin
        if (!psel_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_RESP: begin
        if (!psel_i) begin
          state_d = S_IDLE;
        end else if (penable_i) begin
          commit  = wr_q && inr_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prdata_q <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      inr_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (setup) begin
        wr_q     <= pwrite_i;
        wdata_q  <= pwdata_i;
        idx_q    <= idx;
        inr_q    <= in_range;
        prdata_q <= in_range ? mem_q[idx] : '0;
      end
      if (commit) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign pready_o  = (state_q == S_RESP);
  assign pslverr_o = (state_q == S_RESP) && !inr_q;
  assign prdata_o  = prdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// tb_apb_slave_mem : directed self-checking bench for apb_slave_mem.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int N = 2;
`else
  localparam int N = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int vectors     = 0;
  int miscompares = 0;

  apb_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64),
    .BASE_ADDR(32'hDEADCA00), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  // Called just after a rising edge; returns just after the completion edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    pwdata  = ~wd;
    waits = 0; rd = '0; err = 1'b0;
    forever begin
      @(negedge clk);
      if (pready) begin
        rd  = prdata;
        err = pslverr;
        break;
      end
      waits++;
      if (waits > 20) begin
        vectors++; miscompares++;
        $display("FAIL xfer_timeout addr=%h: pready never rose", addr);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL reset_pready got=%b exp=0", pready); end
    vectors++; if (prdata !== 32'h0) begin miscompares++; $display("FAIL reset_prdata got=%h exp=00000000", prdata); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    @(posedge clk); #1;
  endtask

  task automatic test_first_read();
    logic [31:0] rd; logic err; int w;
    xfer(32'hDEADCAFE, 1'b0, 32'h0, rd, err, w);
    vectors++; if (w !== N) begin miscompares++; $display("FAIL first_read_waits got=%0d exp=%0d", w, N); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL first_read_data got=%h exp=00000000", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL first_read_err got=%b exp=0", err); end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic err; int w;
    xfer(32'hDEADCAFE, 1'b1, 32'h1, rd, err, w);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rmw_write_err got=%b exp=0", err); end
    xfer(32'hDEADCAFE, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL rmw_readback got=%h exp=00000001", rd); end
    for (int i = 0; i < 3; i++) begin
      xfer(32'hDEADCAF8, 1'b0, 32'h0, rd, err, w);
      vectors++; if (rd !== 32'(i)) begin miscompares++; $display("FAIL rmw_loop_read%0d got=%h exp=%h", i, rd, 32'(i)); end
      xfer(32'hDEADCAF8, 1'b1, rd + 32'h1, rd, err, w);
    end
    xfer(32'hDEADCAF8, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h3) begin miscompares++; $display("FAIL rmw_final got=%h exp=00000003", rd); end
  endtask

  task automatic test_wait_read();
    int w = 0;
    logic held = 1'b1;
    psel = 1'b1; penable = 1'b0; paddr = 32'hDEADCA00; pwrite = 1'b0; pwdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    forever begin
      @(negedge clk);
      if (prdata !== 32'h0) held = 1'b0;
      if (pready) break;
      w++;
      if (w > 20) break;
    end
    vectors++; if (w !== N) begin miscompares++; $display("FAIL wait_read_waits got=%0d exp=%0d", w, N); end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL wait_read_prdata_stable got=%b exp=1", held); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL wait_read_err got=%b exp=0", pslverr); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int w;
    xfer(32'hDEADCB00, 1'b1, 32'h12345678, rd, err, w);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oor_write_err got=%b exp=1", err); end
    xfer(32'hDEADCAFF, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h1 || err !== 1'b0) begin miscompares++; $display("FAIL last_byte_alias got=%h/%b exp=00000001/0", rd, err); end
    xfer(32'hDEADCB00, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h0 || err !== 1'b1) begin miscompares++; $display("FAIL oor_read got=%h/%b exp=00000000/1", rd, err); end
    xfer(32'hDEADCA00, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h0 || err !== 1'b0) begin miscompares++; $display("FAIL oor_mem_unchanged got=%h/%b exp=00000000/0", rd, err); end
    xfer(32'hDEADC9FC, 1'b0, 32'h0, rd, err, w);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL below_base_err got=%b exp=1", err); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w;
    psel = 1'b1; penable = 1'b0; paddr = 32'hDEADCA04; pwrite = 1'b1; pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    vectors++; if (pready !== (N == 0)) begin miscompares++; $display("FAIL abort_first_access got=%b exp=%b", pready, (N == 0)); end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL abort_idle got=%b exp=0", pready); end
    @(posedge clk); #1;
    xfer(32'hDEADCA04, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL abort_no_write got=%h exp=00000000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w;
    xfer(32'hDEADCA10, 1'b1, 32'h00000011, rd, err, w);
    xfer(32'hDEADCA10, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h11) begin miscompares++; $display("FAIL b2b_read got=%h exp=00000011", rd); end
    vectors++; if (w !== N) begin miscompares++; $display("FAIL b2b_waits got=%0d exp=%0d", w, N); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w = 0;
    psel = 1'b1; penable = 1'b0; paddr = 32'hDEADCA08; pwrite = 1'b1; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    forever begin
      @(negedge clk);
      if (pready) break;
      w++;
      if (w > 20) break;
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL reset_mid_pready got=%b exp=0", pready); end
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(32'hDEADCA08, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_mid_lost_write got=%h exp=00000000", rd); end
    xfer(32'hDEADCAFE, 1'b0, 32'h0, rd, err, w);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_mid_mem_cleared got=%h exp=00000000", rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_first_read();
    test_rmw();
    test_wait_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
